// File: rtl/cmp_mon_pkg.sv
// Shared encodings for the comparator streak monitor: leader state and event classes.
// Event codes reuse the state encoding so a leader maps straight onto its event code.
package cmp_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_A    = 2'b01,
    ST_B    = 2'b10,
    ST_EQ   = 2'b11
  } state_e;

  localparam logic [1:0] EVT_A  = ST_A;
  localparam logic [1:0] EVT_B  = ST_B;
  localparam logic [1:0] EVT_EQ = ST_EQ;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_cnt;

  // Count register: clear wins, increment stops at the top value
  always_ff @(posedge clk) begin
    if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/cmp_streak_monitor.sv
// Registers comparator flags into a leader FSM, run-length counter, tallies and a one-entry
// event register. Optional macro CMP_MON_ERR_CHECK_EN rejects non-one-hot samples and flags err.
module cmp_streak_monitor
  import cmp_mon_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int STREAK_W  = 4,
  parameter int STREAK_TH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic                out_a,
  input  logic                out_b,
  input  logic                out_eq,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [1:0]          evt_code,
  output logic [STREAK_W-1:0] evt_len,
  output logic [CNT_W-1:0]    win_a,
  output logic [CNT_W-1:0]    win_b,
  output logic [CNT_W-1:0]    tie_cnt,
  output logic [1:0]          state,
  output logic                evt_ovf,
  output logic                err
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = {STREAK_W{1'b1}};
  localparam logic [STREAK_W-1:0] STREAK_ONE = {{(STREAK_W-1){1'b0}}, 1'b1};
  localparam logic [STREAK_W-1:0] TH         = STREAK_TH[STREAK_W-1:0];

  state_e              r_state;
  state_e              w_state_nxt;
  state_e              w_cls;
  logic [STREAK_W-1:0] r_streak;
  logic [STREAK_W-1:0] w_streak_nxt;
  logic                w_legal;
  logic                w_new_run;
  logic                w_fire;
  logic                w_load;
  logic                w_drop;
  logic                r_evt_valid;
  logic [1:0]          r_evt_code;
  logic [STREAK_W-1:0] r_evt_len;
  logic                r_evt_ovf;

`ifdef CMP_MON_ERR_CHECK_EN
  logic                w_bad;
  logic                r_err;

  // Strict decode: only exactly one flag counts, anything else is an error sample
  always_comb begin
    w_legal = 1'b0;
    w_bad   = 1'b0;
    w_cls   = ST_IDLE;
    if (in_valid) begin
      case ({out_a, out_b, out_eq})
        3'b100:  begin w_legal = 1'b1; w_cls = ST_A;  end
        3'b010:  begin w_legal = 1'b1; w_cls = ST_B;  end
        3'b001:  begin w_legal = 1'b1; w_cls = ST_EQ; end
        default: w_bad = 1'b1;
      endcase
    end else begin
      w_legal = 1'b0;
    end
  end

  // Sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_bad) begin
      r_err <= 1'b1;
    end else begin
      r_err <= r_err;
    end
  end

  assign err = r_err;
`else
  // Lenient decode: priority EQ > A > B, zero-hot ignored
  always_comb begin
    w_legal = 1'b0;
    w_cls   = ST_IDLE;
    if (in_valid) begin
      if (out_eq) begin
        w_legal = 1'b1; w_cls = ST_EQ;
      end else if (out_a) begin
        w_legal = 1'b1; w_cls = ST_A;
      end else if (out_b) begin
        w_legal = 1'b1; w_cls = ST_B;
      end else begin
        w_legal = 1'b0;
      end
    end else begin
      w_legal = 1'b0;
    end
  end

  assign err = 1'b0;
`endif

  // Leader state and run-length register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_streak <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_streak <= w_streak_nxt;
    end
  end

  // Next leader / run length from a legal sample
  always_comb begin
    w_state_nxt  = r_state;
    w_streak_nxt = r_streak;
    w_new_run    = 1'b0;
    if (w_legal) begin
      if (w_cls == r_state) begin
        if (r_streak != STREAK_MAX) begin
          w_streak_nxt = r_streak + STREAK_ONE;
        end else begin
          w_streak_nxt = r_streak;
        end
      end else begin
        w_state_nxt  = w_cls;
        w_streak_nxt = STREAK_ONE;
        w_new_run    = 1'b1;
      end
    end else begin
      w_state_nxt = r_state;
    end
  end

  // A saturated run that sits on the threshold must not re-fire, hence the r_streak guard
  always_comb begin
    w_fire = w_legal && (w_streak_nxt == TH) && (w_new_run || (r_streak != TH));
    w_load = 1'b0;
    w_drop = 1'b0;
    if (w_fire) begin
      if (!r_evt_valid || evt_ready) begin
        w_load = 1'b1;
      end else begin
        w_drop = 1'b1;
      end
    end else begin
      w_load = 1'b0;
    end
  end

  // One-entry event register with sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      r_evt_valid <= 1'b0;
      r_evt_code  <= 2'b00;
      r_evt_len   <= '0;
      r_evt_ovf   <= 1'b0;
    end else begin
      if (w_load) begin
        r_evt_valid <= 1'b1;
        r_evt_code  <= w_cls;
        r_evt_len   <= w_streak_nxt;
      end else if (r_evt_valid && evt_ready) begin
        r_evt_valid <= 1'b0;
      end else begin
        r_evt_valid <= r_evt_valid;
      end
      if (w_drop) begin
        r_evt_ovf <= 1'b1;
      end else begin
        r_evt_ovf <= r_evt_ovf;
      end
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_win_a (
    .clk (clk), .clr (rst), .inc (w_legal && (w_cls == ST_A)),  .cnt (win_a)
  );
  sat_counter #(.WIDTH(CNT_W)) u_win_b (
    .clk (clk), .clr (rst), .inc (w_legal && (w_cls == ST_B)),  .cnt (win_b)
  );
  sat_counter #(.WIDTH(CNT_W)) u_tie (
    .clk (clk), .clr (rst), .inc (w_legal && (w_cls == ST_EQ)), .cnt (tie_cnt)
  );

  assign state     = r_state;
  assign evt_valid = r_evt_valid;
  assign evt_code  = r_evt_code;
  assign evt_len   = r_evt_len;
  assign evt_ovf   = r_evt_ovf;

endmodule

// File: tb/tb_cmp_streak_monitor.sv
// Directed bench for cmp_streak_monitor: a reference model predicts every cycle and events
// are queued on prediction and popped when the DUT hands them over.
module tb_cmp_streak_monitor;

  localparam int TH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0, out_a = 1'b0, out_b = 1'b0, out_eq = 1'b0;
  logic       evt_ready = 1'b0;
  logic       evt_valid, evt_ovf, err;
  logic [1:0] evt_code, state;
  logic [3:0] evt_len;
  logic [7:0] win_a, win_b, tie_cnt;

  logic       evt_valid3, evt_ovf3, err3;
  logic [1:0] evt_code3, state3;
  logic [3:0] evt_len3;
  logic [2:0] win_a3, win_b3, tie_cnt3;

  int errors = 0;
  int checks = 0;
  int n_acc  = 0;
  int ev3    = 0;

  logic [1:0] m_state;
  int         m_streak;
  int         m_tal [3];
  logic       m_pend, m_ovf, m_err;
  logic [5:0] q [$];

  cmp_streak_monitor #(.CNT_W(8), .STREAK_W(4), .STREAK_TH(TH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .out_a(out_a), .out_b(out_b), .out_eq(out_eq),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code), .evt_len(evt_len),
    .win_a(win_a), .win_b(win_b), .tie_cnt(tie_cnt), .state(state), .evt_ovf(evt_ovf), .err(err)
  );

  cmp_streak_monitor #(.CNT_W(3), .STREAK_W(4), .STREAK_TH(TH)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .out_a(out_a), .out_b(out_b), .out_eq(out_eq),
    .evt_valid(evt_valid3), .evt_ready(evt_ready), .evt_code(evt_code3), .evt_len(evt_len3),
    .win_a(win_a3), .win_b(win_b3), .tie_cnt(tie_cnt3), .state(state3), .evt_ovf(evt_ovf3),
    .err(err3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one clock of stimulus (called at a negedge), advance the model, check at next negedge
  task automatic cycle(input logic v, input logic a, input logic b, input logic eq,
                       input logic rdy);
    logic       legal;
    logic       fire;
    logic       new_run;
    logic [1:0] cls;
    int         prev;
    in_valid = v; out_a = a; out_b = b; out_eq = eq; evt_ready = rdy;
    if (m_pend && rdy) begin
      chk("accept_event", {26'd0, evt_code, evt_len}, {26'd0, q[0]});
      void'(q.pop_front());
      m_pend = 1'b0;
      n_acc++;
    end
    cls = 2'b00;
    if (v) begin
`ifdef CMP_MON_ERR_CHECK_EN
      if ({a, b, eq} == 3'b100)      cls = 2'b01;
      else if ({a, b, eq} == 3'b010) cls = 2'b10;
      else if ({a, b, eq} == 3'b001) cls = 2'b11;
      else                           m_err = 1'b1;
`else
      if (eq)     cls = 2'b11;
      else if (a) cls = 2'b01;
      else if (b) cls = 2'b10;
`endif
    end
    legal = (cls != 2'b00);
    fire  = 1'b0;
    if (legal) begin
      prev = m_streak;
      if (cls == m_state) begin
        new_run = 1'b0;
        if (m_streak < 15) m_streak++;
      end else begin
        new_run  = 1'b1;
        m_state  = cls;
        m_streak = 1;
      end
      if (m_tal[cls-1] < 255) m_tal[cls-1]++;
      fire = (m_streak == TH) && (new_run || prev != TH);
    end
    if (fire) begin
      if (!m_pend) begin
        q.push_back({cls, 4'(m_streak)});
        m_pend = 1'b1;
      end else begin
        m_ovf = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("evt_valid", {31'd0, evt_valid}, {31'd0, m_pend});
    chk("state",     {30'd0, state},     {30'd0, m_state});
    chk("win_a",     {24'd0, win_a},     m_tal[0]);
    chk("win_b",     {24'd0, win_b},     m_tal[1]);
    chk("tie_cnt",   {24'd0, tie_cnt},   m_tal[2]);
    chk("evt_ovf",   {31'd0, evt_ovf},   {31'd0, m_ovf});
    chk("err",       {31'd0, err},       {31'd0, m_err});
    if (m_pend) chk("pending_event", {26'd0, evt_code, evt_len}, {26'd0, q[0]});
  endtask

  // Code: 0 = no valid, 1 = A, 2 = B, 3 = EQ
  task automatic samp(input logic [1:0] code, input logic rdy);
    cycle(code != 2'd0, code == 2'd1, code == 2'd2, code == 2'd3, rdy);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_a = 1'b0; out_b = 1'b0; out_eq = 1'b0; evt_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_state = 2'b00; m_streak = 0; m_tal = '{0, 0, 0};
    m_pend = 1'b0; m_ovf = 1'b0; m_err = 1'b0;
    q.delete();
    n_acc = 0;
    chk("rst_valid", {31'd0, evt_valid}, 32'd0);
    chk("rst_code",  {30'd0, evt_code},  32'd0);
    chk("rst_len",   {28'd0, evt_len},   32'd0);
    chk("rst_state", {30'd0, state},     32'd0);
    chk("rst_tally", {8'd0, win_a, win_b, tie_cnt}, 32'd0);
    chk("rst_flags", {30'd0, evt_ovf, err}, 32'd0);
    chk("rst_tie3",  {29'd0, tie_cnt3},  32'd0);
  endtask

  initial begin
    logic [1:0] seq2 [10];
    seq2 = '{2'd1, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd1, 2'd0, 2'd1, 2'd1};

    // Basic A run
    do_reset();
    for (int i = 0; i < 4; i++) samp(2'd1, 1'b1);
    chk("t1_state", {30'd0, state}, 32'd1);
    chk("t1_code",  {30'd0, evt_code}, 32'd1);
    chk("t1_len",   {28'd0, evt_len}, 32'd4);
    chk("t1_win_a", {24'd0, win_a}, 32'd4);
    samp(2'd0, 1'b1);
    samp(2'd0, 1'b1);
    chk("t1_events", n_acc, 32'd1);

    // Broken run with invalid gaps
    do_reset();
    for (int i = 0; i < 10; i++) samp(seq2[i], 1'b1);
    samp(2'd0, 1'b1);
    samp(2'd0, 1'b1);
    chk("t2_events", n_acc, 32'd1);
    chk("t2_win_b",  {24'd0, win_b}, 32'd1);
    chk("t2_win_a",  {24'd0, win_a}, 32'd6);

    // Back-pressure: second event dropped
    do_reset();
    for (int i = 0; i < 4; i++) samp(2'd1, 1'b0);
    for (int i = 0; i < 4; i++) samp(2'd2, 1'b0);
    samp(2'd0, 1'b0);
    chk("t3_ovf",   {31'd0, evt_ovf}, 32'd1);
    chk("t3_code",  {30'd0, evt_code}, 32'd1);
    chk("t3_state", {30'd0, state}, 32'd2);
    samp(2'd0, 1'b1);
    samp(2'd0, 1'b1);
    chk("t3_events", n_acc, 32'd1);
    chk("t3_drained", {31'd0, evt_valid}, 32'd0);

    // Tally saturation on the narrow instance
    do_reset();
    ev3 = 0;
    for (int i = 0; i < 10; i++) begin
      samp(2'd3, 1'b1);
      if (evt_valid3) ev3++;
    end
    samp(2'd0, 1'b1);
    chk("t4_tie3",   {29'd0, tie_cnt3}, 32'd7);
    chk("t4_ev3",    ev3, 32'd1);
    chk("t4_tie",    {24'd0, tie_cnt}, 32'd10);
    chk("t4_events", n_acc, 32'd1);

    // Multi-hot sample
    do_reset();
    samp(2'd2, 1'b1);
    samp(2'd2, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
`ifdef CMP_MON_ERR_CHECK_EN
    chk("t5_err",   {31'd0, err}, 32'd1);
    chk("t5_state", {30'd0, state}, 32'd2);
    chk("t5_win_a", {24'd0, win_a}, 32'd0);
`else
    chk("t5_err",   {31'd0, err}, 32'd0);
    chk("t5_state", {30'd0, state}, 32'd1);
    chk("t5_win_a", {24'd0, win_a}, 32'd1);
`endif

    // Reset with an event pending mid-streak
    do_reset();
    for (int i = 0; i < 6; i++) samp(2'd1, 1'b0);
    chk("t6_pending", {31'd0, evt_valid}, 32'd1);
    do_reset();
    samp(2'd0, 1'b1);
    chk("t6_after", {31'd0, evt_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
